// File: rtl/md_lr_pkg.sv
// Shared types and constants for the long-range force receive path.
// The receiver buffers force beats from the core and presents them to the host in CSRW-wide segments.
package md_lr_pkg;

    localparam int FDATAW = 96;
    localparam int CSRW   = 16;
    localparam int NSEG   = FDATAW / CSRW;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/md_lr_sync_fifo.sv
// Synchronous FIFO with a registered head word, an occupancy count and a synchronous clear.
// Pointers wrap modulo DEPTH; the separate count tells full from empty.
module md_lr_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wptr_r;
    logic [AW-1:0]    rptr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] rdata_r;
    logic             rvalid_r;

    logic             push_s;
    logic             pop_s;
    logic [AW-1:0]    rptr_nxt_s;
    logic [CW-1:0]    count_nxt_s;
    logic [WIDTH-1:0] head_nxt_s;

    assign push_s = push && (count_r != CW'(DEPTH));
    assign pop_s  = pop && (count_r != CW'(0));

    // Next read pointer, occupancy and head word
    always_comb begin
        rptr_nxt_s  = pop_s ? (rptr_r + AW'(1)) : rptr_r;
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
        // A word written this cycle becomes the head when it lands on the next read slot.
        if (count_nxt_s == CW'(0)) begin
            head_nxt_s = '0;
        end else if (push_s && (rptr_nxt_s == wptr_r)) begin
            head_nxt_s = wdata;
        end else begin
            head_nxt_s = mem_r[rptr_nxt_s];
        end
    end

    // Storage array write port; clear and reset suppress the write
    always_ff @(posedge clk) begin
        if (!rst && !clr && push_s) begin
            mem_r[wptr_r] <= wdata;
        end
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wptr_r   <= '0;
            rptr_r   <= '0;
            count_r  <= '0;
            rdata_r  <= '0;
            rvalid_r <= 1'b0;
        end else begin
            wptr_r   <= push_s ? (wptr_r + AW'(1)) : wptr_r;
            rptr_r   <= rptr_nxt_s;
            count_r  <= count_nxt_s;
            rdata_r  <= head_nxt_s;
            rvalid_r <= (count_nxt_s != CW'(0));
        end
    end

    assign rdata  = rdata_r;
    assign rvalid = rvalid_r;
    assign full   = (count_r == CW'(DEPTH));
    assign count  = count_r;

endmodule

// File: rtl/md_lr_force_rx.sv
// Force receiver: accepts core force beats into a FIFO, exposes the head to the host by segment,
// and tracks run progress (IDLE -> STREAM -> DRAIN -> DONE) until the host re-arms it with hclr.
module md_lr_force_rx
    import md_lr_pkg::*;
#(
    parameter int MAXNUMP = 32768,
    parameter int FDATAW  = md_lr_pkg::FDATAW,
    parameter int CSRW    = md_lr_pkg::CSRW,
    parameter int DEPTH   = 4,
    localparam int PADDRW = $clog2(MAXNUMP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fvalid,
    output logic              fready,
    input  logic [PADDRW-1:0] faddr,
    input  logic [FDATAW-1:0] fdata,
    input  logic              flast,
    input  logic              hpop,
    input  logic              hclr,
    input  logic [2:0]        hsel,
    output logic              hvalid,
    output logic [CSRW-1:0]   hseg,
    output logic [PADDRW-1:0] haddr,
    output logic              hlast,
    output logic [PADDRW:0]   fcount,
    output logic              done,
    output logic              perr
);

    localparam int NSEG   = FDATAW / CSRW;
    localparam int EWIDTH = PADDRW + FDATAW + 1;
    localparam int CW     = $clog2(DEPTH) + 1;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [PADDRW:0]     fcount_r;
    logic                perr_r;
    logic                done_r;

    logic                fready_s;
    logic                accept_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [CW-1:0]       fifo_count_s;
    logic [EWIDTH-1:0]   fifo_rdata_s;
    logic                hvalid_s;
    logic [FDATAW-1:0]   head_data_s;
    logic [CSRW-1:0]     seg_s;

    // Ready depends only on registered state and occupancy, never on fvalid.
    assign fready_s     = ((state_r == ST_IDLE) || (state_r == ST_STREAM)) && !fifo_full_s;
    assign accept_s     = fvalid && fready_s;
    assign fifo_empty_s = (fifo_count_s == CW'(0));

    md_lr_sync_fifo #(
        .WIDTH (EWIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .clr    (hclr),
        .push   (accept_s),
        .pop    (hpop),
        .wdata  ({flast, faddr, fdata}),
        .rdata  (fifo_rdata_s),
        .rvalid (hvalid_s),
        .full   (fifo_full_s),
        .count  (fifo_count_s)
    );

    // Run-progress next-state logic; hclr overrides every transition
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = flast ? ST_DRAIN : ST_STREAM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (accept_s && flast) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_DONE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (hclr) begin
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // State register, beat counter, protocol error flag and done flag
    always_ff @(posedge clk) begin
        if (rst || hclr) begin
            state_r  <= ST_IDLE;
            fcount_r <= '0;
            perr_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= (state_nxt_s == ST_DONE);
            if (accept_s && (fcount_r != {(PADDRW + 1){1'b1}})) begin
                fcount_r <= fcount_r + (PADDRW + 1)'(1);
            end
            if (hpop && !hvalid_s) begin
                perr_r <= 1'b1;
            end
        end
    end

    assign head_data_s = fifo_rdata_s[FDATAW-1:0];

    // Segment select as an OR-mux; out-of-range selects match nothing and read as zero
    always_comb begin
        seg_s = '0;
        for (int i = 0; i < NSEG; i++) begin
            seg_s = seg_s | ((hsel == 3'(i)) ? head_data_s[i*CSRW +: CSRW] : {CSRW{1'b0}});
        end
    end

    assign fready = fready_s;
    assign hvalid = hvalid_s;
    assign hseg   = hvalid_s ? seg_s : {CSRW{1'b0}};
    assign haddr  = fifo_rdata_s[FDATAW +: PADDRW];
    assign hlast  = fifo_rdata_s[FDATAW + PADDRW];
    assign fcount = fcount_r;
    assign done   = done_r;
    assign perr   = perr_r;

endmodule
